// File: rtl/key_event_detector.sv
// Turns debounced key levels into one-cycle press/release/long-press/repeat events.
// Hold timing is counted in ticks of the shared debounce strobe, not in clock cycles.
module key_event_detector #(
    parameter int unsigned NUM_KEYS            = 8,
    parameter int unsigned LONG_PRESS_TICKS    = 200,
    parameter int unsigned REPEAT_PERIOD_TICKS = 40
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                tick,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] released,
    output logic [NUM_KEYS-1:0] long_pressed,
    output logic [NUM_KEYS-1:0] repeat_pulse,
    output logic [NUM_KEYS-1:0] held
);

    localparam int unsigned MAX_TICKS   = (LONG_PRESS_TICKS > REPEAT_PERIOD_TICKS) ?
                                          LONG_PRESS_TICKS : REPEAT_PERIOD_TICKS;
    localparam int unsigned CNT_W       = $clog2(MAX_TICKS + 1);
    localparam int unsigned LONG_LAST   = LONG_PRESS_TICKS - 1;
    localparam int unsigned REPEAT_LAST = (REPEAT_PERIOD_TICKS == 0) ? 0 : REPEAT_PERIOD_TICKS - 1;
    localparam bit          REPEAT_EN   = (REPEAT_PERIOD_TICKS != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             prev_q;
        logic             rise, fall;
        logic             pressed_q, pressed_d;
        logic             released_q, released_d;
        logic             long_q, long_d;
        logic             repeat_q, repeat_d;
        logic             held_q, held_d;

        assign rise = keys[g] & ~prev_q;
        assign fall = ~keys[g] & prev_q;

        // prev captures keys even in reset so a key held through reset needs a fresh edge
        always_ff @(posedge clock) begin
            prev_q <= keys[g];
            if (!reset_n) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
                long_q     <= 1'b0;
                repeat_q   <= 1'b0;
                held_q     <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                pressed_q  <= pressed_d;
                released_q <= released_d;
                long_q     <= long_d;
                repeat_q   <= repeat_d;
                held_q     <= held_d;
            end
        end

        // A fall outranks a same-cycle tick; a rise with a tick counts only the rise
        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            pressed_d  = 1'b0;
            released_d = 1'b0;
            long_d     = 1'b0;
            repeat_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        pressed_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (fall) begin
                        released_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                    end else if (tick) begin
                        if (cnt_q == CNT_W'(LONG_LAST)) begin
                            long_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_LONG;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_LONG: begin
                    if (fall) begin
                        released_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                    end else if (tick && REPEAT_EN) begin
                        if (cnt_q == CNT_W'(REPEAT_LAST)) begin
                            repeat_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            held_d = (state_d != ST_IDLE);
        end

        assign pressed[g]      = pressed_q;
        assign released[g]     = released_q;
        assign long_pressed[g] = long_q;
        assign repeat_pulse[g] = repeat_q;
        assign held[g]         = held_q;
    end

endmodule

// File: tb/tb_key_event_detector.sv
// Bench for key_event_detector: one instance with repeat enabled, one with repeat disabled,
// both checked every cycle against a tick-counting event model.
module tb_key_event_detector;

    localparam int LONG_T = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] keys = 2'b00;

    logic [1:0] pressed_a, released_a, long_a, rep_a, held_a;
    logic [1:0] pressed_b, released_b, long_b, rep_b, held_b;
    logic [9:0] got_a, got_b;

    assign got_a = {pressed_a, released_a, long_a, rep_a, held_a};
    assign got_b = {pressed_b, released_b, long_b, rep_b, held_b};

    key_event_detector #(.NUM_KEYS(2), .LONG_PRESS_TICKS(4), .REPEAT_PERIOD_TICKS(2)) dut_a (
        .clock(clk), .reset_n(reset_n), .tick(tick), .keys(keys),
        .pressed(pressed_a), .released(released_a), .long_pressed(long_a),
        .repeat_pulse(rep_a), .held(held_a)
    );

    key_event_detector #(.NUM_KEYS(2), .LONG_PRESS_TICKS(4), .REPEAT_PERIOD_TICKS(0)) dut_b (
        .clock(clk), .reset_n(reset_n), .tick(tick), .keys(keys),
        .pressed(pressed_b), .released(released_b), .long_pressed(long_b),
        .repeat_pulse(rep_b), .held(held_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: per channel, whether the key counts as down and how many ticks since the press
    bit   [1:0] down [2];
    int         nticks [2][2];
    logic [1:0] mprev = 2'b00;
    logic [9:0] exp_o [2];

    task automatic model(input logic [1:0] k, input logic t, input logic r);
        logic [1:0] p, rl, l, rp, h;
        int rep;
        for (int i = 0; i < 2; i++) begin
            rep = (i == 0) ? 2 : 0;
            p = '0; rl = '0; l = '0; rp = '0; h = '0;
            for (int j = 0; j < 2; j++) begin
                if (!r) begin
                    down[i][j] = 1'b0;
                    nticks[i][j] = 0;
                end else if (!down[i][j]) begin
                    if (k[j] && !mprev[j]) begin
                        p[j] = 1'b1;
                        down[i][j] = 1'b1;
                        nticks[i][j] = 0;
                    end
                end else if (!k[j]) begin
                    rl[j] = 1'b1;
                    down[i][j] = 1'b0;
                end else if (t) begin
                    nticks[i][j]++;
                    if (nticks[i][j] == LONG_T) l[j] = 1'b1;
                    else if (rep != 0 && nticks[i][j] > LONG_T &&
                             (nticks[i][j] - LONG_T) % rep == 0) rp[j] = 1'b1;
                end
                h[j] = down[i][j];
            end
            exp_o[i] = {p, rl, l, rp, h};
        end
        mprev = k;
    endtask

    function automatic logic tick_now();
        return (cyc % 10) == 9;
    endfunction

    // Drive on the falling edge, update the model at the rising edge, return 1 time unit later
    task automatic step(input logic [1:0] k, input logic t, input logic r);
        @(negedge clk);
        keys = k; tick = t; reset_n = r;
        @(posedge clk);
        model(k, t, r);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        step(2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        checks++;
        if (got_a !== 10'b0) begin
            errors++;
            $display("FAIL reset_a: got %b expected %b", got_a, 10'b0);
        end
        checks++;
        if (got_b !== 10'b0) begin
            errors++;
            $display("FAIL reset_b: got %b expected %b", got_b, 10'b0);
        end
        step(2'b00, 1'b0, 1'b1);
        checks++;
        if (got_a !== exp_o[0]) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", got_a, exp_o[0]);
        end
    endtask

    task automatic test_short_press();
        int np = 0, nr = 0, nl = 0, nh = 0;
        for (int c = 0; c < 32; c++) begin
            step((c >= 1 && c < 26) ? 2'b01 : 2'b00, tick_now(), 1'b1);
            np += pressed_a[0]; nr += released_a[0]; nl += long_a[0]; nh += held_a[0];
            checks++;
            if (got_a !== exp_o[0] || got_b !== exp_o[1]) begin
                errors++;
                $display("FAIL short_press c=%0d: got %b/%b expected %b/%b", c, got_a, got_b, exp_o[0], exp_o[1]);
            end
        end
        checks++;
        if (np != 1 || nr != 1 || nl != 0 || nh != 25) begin
            errors++;
            $display("FAIL short_press_counts: got p=%0d r=%0d l=%0d h=%0d expected 1 1 0 25", np, nr, nl, nh);
        end
    endtask

    task automatic test_long_repeat();
        int ticks = 0, nl = 0, nra = 0, nrb = 0, nlb = 0;
        logic t;
        while (tick_now()) step(2'b00, 1'b1, 1'b1);
        step(2'b01, 1'b0, 1'b1);
        while (ticks < 20) begin
            t = tick_now();
            step(2'b01, t, 1'b1);
            if (t) ticks++;
            nl += long_a[0]; nra += rep_a[0]; nlb += long_b[0]; nrb += rep_b[0];
            if (ticks == 10 && t) begin
                checks++;
                if (nl != 1 || nra != 3) begin
                    errors++;
                    $display("FAIL long_repeat_a: got long=%0d rep=%0d expected 1 3", nl, nra);
                end
            end
            checks++;
            if (got_a !== exp_o[0] || got_b !== exp_o[1]) begin
                errors++;
                $display("FAIL long_repeat tick=%0d: got %b/%b expected %b/%b", ticks, got_a, got_b, exp_o[0], exp_o[1]);
            end
        end
        checks++;
        if (nlb != 1 || nrb != 0) begin
            errors++;
            $display("FAIL repeat_disabled: got long=%0d rep=%0d expected 1 0", nlb, nrb);
        end
        step(2'b00, tick_now(), 1'b1);
        checks++;
        if (released_a[0] !== 1'b1 || released_b[0] !== 1'b1) begin
            errors++;
            $display("FAIL long_release: got %b%b expected 11", released_a[0], released_b[0]);
        end
        repeat (3) step(2'b00, tick_now(), 1'b1);
    endtask

    task automatic test_release_on_tick();
        int ticks = 0, nl = 0;
        logic t;
        logic done = 1'b0;
        while (tick_now()) step(2'b00, 1'b1, 1'b1);
        step(2'b01, 1'b0, 1'b1);
        while (!done) begin
            t = tick_now();
            done = t && ticks == 3;
            step(done ? 2'b00 : 2'b01, t, 1'b1);
            if (t) ticks++;
            nl += long_a[0] | long_b[0];
        end
        checks++;
        if (released_a[0] !== 1'b1 || got_a !== exp_o[0]) begin
            errors++;
            $display("FAIL release_on_tick: got %b expected %b", got_a, exp_o[0]);
        end
        for (int c = 0; c < 12; c++) begin
            step(2'b00, tick_now(), 1'b1);
            nl += long_a[0] | long_b[0];
        end
        checks++;
        if (nl != 0 || held_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL release_on_tick_idle: got long=%0d held=%b expected 0 0", nl, held_a[0]);
        end
    endtask

    task automatic test_held_through_reset();
        int np = 0;
        step(2'b10, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        for (int c = 0; c < 15; c++) begin
            step(2'b10, tick_now(), 1'b1);
            np += pressed_a[1];
            checks++;
            if (got_a !== exp_o[0]) begin
                errors++;
                $display("FAIL held_through_reset c=%0d: got %b expected %b", c, got_a, exp_o[0]);
            end
        end
        checks++;
        if (np != 0) begin
            errors++;
            $display("FAIL held_through_reset_press: got %0d expected 0", np);
        end
        step(2'b00, tick_now(), 1'b1);
        checks++;
        if (released_a[1] !== 1'b0) begin
            errors++;
            $display("FAIL held_through_reset_drop: got released %b expected 0", released_a[1]);
        end
        step(2'b10, tick_now(), 1'b1);
        checks++;
        if (pressed_a[1] !== 1'b1 || held_a[1] !== 1'b1) begin
            errors++;
            $display("FAIL fresh_press: got p=%b h=%b expected 1 1", pressed_a[1], held_a[1]);
        end
        repeat (2) step(2'b00, tick_now(), 1'b1);
    endtask

    task automatic test_independence_reset();
        int ticks = 0;
        logic t;
        step(2'b01, 1'b0, 1'b1);
        while (ticks < 6) begin
            t = tick_now();
            step(ticks >= 5 ? 2'b11 : 2'b01, t, 1'b1);
            if (t) ticks++;
        end
        for (int c = 0; c < 25; c++) begin
            step(2'b11, tick_now(), 1'b1);
            checks++;
            if (got_a !== exp_o[0] || got_b !== exp_o[1]) begin
                errors++;
                $display("FAIL independence c=%0d: got %b/%b expected %b/%b", c, got_a, got_b, exp_o[0], exp_o[1]);
            end
        end
        step(2'b11, tick_now(), 1'b0);
        checks++;
        if (held_a !== 2'b00 || released_a !== 2'b00 || held_b !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: got held=%b rel=%b held_b=%b expected 00 00 00", held_a, released_a, held_b);
        end
        step(2'b00, tick_now(), 1'b1);
        checks++;
        if (released_a !== 2'b00 || got_a !== exp_o[0]) begin
            errors++;
            $display("FAIL post_reset_drop: got %b expected %b", got_a, exp_o[0]);
        end
    endtask

    task automatic test_random();
        logic [1:0] k = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            for (int j = 0; j < 2; j++)
                if ($urandom_range(0, 7) == 0) k[j] = ~k[j];
            step(k, $urandom_range(0, 4) == 0, $urandom_range(0, 299) != 0);
            checks++;
            if (got_a !== exp_o[0] || got_b !== exp_o[1]) begin
                errors++;
                $display("FAIL random c=%0d: got %b/%b expected %b/%b", c, got_a, got_b, exp_o[0], exp_o[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_repeat();
        test_release_on_tick();
        test_held_through_reset();
        test_independence_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
